// File: rtl/rxd_fifo_receiver.sv
// rxd_fifo_receiver: oversampling UART receiver feeding a first-word-fall-through
// FIFO, with sticky overrun / framing (and optional parity) error flags.
// Optional feature macro: RXD_PARITY_EN adds one even-parity bit after the data bits.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line idle, waiting for a synced falling edge on SDI
// S_START  | half a bit time into the start bit, confirm it is still low
// S_DATA   | sample DATA_BITS data bits, LSB first, one per bit time
// S_PARITY | sample the even-parity bit (RXD_PARITY_EN builds only)
// S_STOP   | sample the stop bit, request a push or flag a framing error
module rxd_fifo_receiver #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          Clock,
    input  logic                          Reset_n,
    input  logic                          SDI,
    input  logic                          ReadEnable,
    input  logic                          ClearData,
    output logic [DATA_BITS-1:0]          CurrentData,
    output logic                          DataAvailable,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
    output logic                          Overrun,
    output logic                          FramingError,
    output logic                          ParityError
);

    localparam int BIT_TICKS = (CLOCK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF      = BIT_TICKS / 2;
    localparam int CW        = $clog2(BIT_TICKS) + 1;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int IW        = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BIT_C    = CW'(BIT_TICKS);
    localparam logic [CW-1:0] HALF_C   = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT1_F   = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 push_req;
    logic                 frame_err;
    logic                 sdi_meta;
    logic                 sdi_sync;
    logic                 sdi_prev;
    logic                 tick_done;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 empty;
    logic                 full;
    logic                 do_pop;
    logic                 do_push;

`ifdef RXD_PARITY_EN
    logic                 parity_err;
    logic                 par_bad;
`endif

    assign tick_done = (cnt == CNT_ONE);

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sdi_meta <= 1'b1;
            sdi_sync <= 1'b1;
            sdi_prev <= 1'b1;
        end else begin
            sdi_meta <= SDI;
            sdi_sync <= sdi_meta;
            sdi_prev <= sdi_sync;
        end
    end

    // Receiver FSM: down-counter times each bit, outputs are one-cycle registered pulses.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef RXD_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef RXD_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (sdi_prev && !sdi_sync) begin
                        cnt   <= HALF_C;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick_done) begin
                        if (!sdi_sync) begin
                            cnt   <= BIT_C;
                            idx   <= '0;
                            state <= S_DATA;
`ifdef RXD_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (tick_done) begin
                        shreg <= {sdi_sync, shreg[DATA_BITS-1:1]};
                        cnt   <= BIT_C;
                        if (idx == LAST_IDX) begin
`ifdef RXD_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
`ifdef RXD_PARITY_EN
                S_PARITY: begin
                    if (tick_done) begin
                        par_bad    <= (^shreg) ^ sdi_sync;
                        parity_err <= (^shreg) ^ sdi_sync;
                        cnt        <= BIT_C;
                        state      <= S_STOP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_done) begin
                        state <= S_IDLE;
                        if (sdi_sync) begin
`ifdef RXD_PARITY_EN
                            push_req <= !par_bad;
`else
                            push_req <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_pop  = ReadEnable && !empty;
    assign do_push = push_req && (!full || do_pop);

    // FIFO pointers and occupancy; a flush overrides any push or pop that cycle.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ClearData) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT1_F;
            else if (!do_push && do_pop) count <= count - CNT1_F;
        end
    end

    // FIFO storage; no reset needed since empty entries are masked at the output.
    always_ff @(posedge Clock) begin
        if (do_push && !ClearData) mem[wr_ptr] <= shreg;
    end

    // Sticky error flags, cleared only by flush or reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Overrun      <= 1'b0;
            FramingError <= 1'b0;
        end else if (ClearData) begin
            Overrun      <= 1'b0;
            FramingError <= 1'b0;
        end else begin
            if (push_req && full && !do_pop) Overrun <= 1'b1;
            if (frame_err) FramingError <= 1'b1;
        end
    end

`ifdef RXD_PARITY_EN
    // Sticky parity flag.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)        ParityError <= 1'b0;
        else if (ClearData)  ParityError <= 1'b0;
        else if (parity_err) ParityError <= 1'b1;
    end
`else
    assign ParityError = 1'b0;
`endif

    assign CurrentData   = empty ? '0 : mem[rd_ptr];
    assign DataAvailable = !empty;
    assign FifoCount     = count;

endmodule

// File: tb/tb_rxd_fifo_receiver.sv
// Testbench for rxd_fifo_receiver: serial frames driven on SDI, FIFO contents and
// flags compared with a queue-based model of the receive buffer.
module tb_rxd_fifo_receiver;

`ifdef RXD_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       SDI = 1'b1;
    logic       ReadEnable = 1'b0;
    logic       ClearData = 1'b0;
    logic [7:0] CurrentData;
    logic       DataAvailable;
    logic [2:0] FifoCount;
    logic       Overrun, FramingError, ParityError;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit m_ovr, m_fe, m_pe;

    logic [14:0] obs;
    assign obs = {DataAvailable, FifoCount, CurrentData, Overrun, FramingError, ParityError};

    rxd_fifo_receiver #(
        .CLOCK_FREQ(1000000),
        .BAUD(100000),
        .DATA_BITS(8),
        .FIFO_DEPTH(4)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .SDI(SDI),
        .ReadEnable(ReadEnable),
        .ClearData(ClearData),
        .CurrentData(CurrentData),
        .DataAvailable(DataAvailable),
        .FifoCount(FifoCount),
        .Overrun(Overrun),
        .FramingError(FramingError),
        .ParityError(ParityError)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] exp_status();
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        return {q.size() != 0, 3'(q.size()), head, m_ovr, m_fe, m_pe};
    endfunction

    // Model of one received frame: applied once the frame is complete.
    task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        if (!stop_bit) m_fe = 1'b1;
`ifdef RXD_PARITY_EN
        if (bad_par) m_pe = 1'b1;
`else
        bad_par = 1'b0;
`endif
        if (stop_bit && !bad_par) begin
            if (q.size() == 4) m_ovr = 1'b1;
            else q.push_back(d);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovr = 0; m_fe = 0; m_pe = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        @(posedge Clock) #2 SDI = 1'b0;
        repeat (10) @(posedge Clock);
        for (int i = 0; i < 8; i++) begin
            #2 SDI = d[i];
            repeat (10) @(posedge Clock);
        end
`ifdef RXD_PARITY_EN
        #2 SDI = (^d) ^ bad_par;
        repeat (10) @(posedge Clock);
`endif
        #2 SDI = stop_bit;
        repeat (10) @(posedge Clock);
        #2 SDI = 1'b1;
    endtask

    task automatic do_pop();
        @(posedge Clock) #2 ReadEnable = 1'b1;
        @(posedge Clock) #2 ReadEnable = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic do_clear();
        @(posedge Clock) #2 ClearData = 1'b1;
        @(posedge Clock) #2 ClearData = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clock);
        #1 checks++;
        if (obs !== 15'h0) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, 15'h0); end
        #3 Reset_n = 1'b1;
        model_clear();
        repeat (5) @(posedge Clock);
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL after_reset got=%h exp=%h", obs, exp_status()); end
    endtask

    task automatic test_single();
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (FB * 10 - 6) @(posedge Clock);
                #1 checks++;
                if (DataAvailable !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", DataAvailable); end
                repeat (8) @(posedge Clock);
                #1 checks++;
                if ({DataAvailable, CurrentData, FifoCount} !== {1'b1, 8'hA5, 3'd1}) begin
                    failures++; $display("FAIL single_arrival got=%b/%h/%0d exp=1/a5/1", DataAvailable, CurrentData, FifoCount);
                end
            end
        join
        model_frame(8'hA5, 1'b1, 1'b0);
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL single_status got=%h exp=%h", obs, exp_status()); end
        do_pop();
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL single_pop got=%h exp=%h", obs, exp_status()); end
        do_pop();
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL pop_empty got=%h exp=%h", obs, exp_status()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3] = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) begin
            send_frame(exp_b[i], 1'b1, 1'b0);
            model_frame(exp_b[i], 1'b1, 1'b0);
        end
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL b2b_status got=%h exp=%h", obs, exp_status()); end
        for (int i = 0; i < 3; i++) begin
            #1 checks++;
            if (CurrentData !== exp_b[i]) begin failures++; $display("FAIL b2b_read%0d got=%h exp=%h", i, CurrentData, exp_b[i]); end
            do_pop();
        end
        #1 checks++;
        if ({DataAvailable, CurrentData} !== 9'h0) begin failures++; $display("FAIL b2b_drained got=%b/%h exp=0/00", DataAvailable, CurrentData); end
    endtask

    // Frame whose push lands in the same cycle as a pop of a full FIFO.
    task automatic frame_with_pop(input logic [7:0] d);
        fork
            send_frame(d, 1'b1, 1'b0);
            begin
                repeat (FB * 10 - 1) @(posedge Clock);
                #2 ReadEnable = 1'b1;
                @(posedge Clock) #2 ReadEnable = 1'b0;
            end
        join
        if (q.size() != 0) void'(q.pop_front());
        model_frame(d, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'h10 + 8'(i);
            send_frame(b, 1'b1, 1'b0);
            model_frame(b, 1'b1, 1'b0);
        end
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL overrun_status got=%h exp=%h", obs, exp_status()); end
        frame_with_pop(8'h16);
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL full_push_pop got=%h exp=%h", obs, exp_status()); end
        while (q.size() != 0) begin
            b = q[0];
            #1 checks++;
            if (CurrentData !== b) begin failures++; $display("FAIL overrun_drain got=%h exp=%h", CurrentData, b); end
            do_pop();
        end
        do_clear();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0);
            model_frame(b, 1'b1, 1'b0);
        end
        frame_with_pop(8'($urandom));
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL full_push_pop_noovr got=%h exp=%h", obs, exp_status()); end
        do_pop();
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL full_push_pop_next got=%h exp=%h", obs, exp_status()); end
    endtask

    task automatic test_framing();
        logic [7:0] b;
        do_clear();
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        model_frame(b, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL framing got=%h exp=%h", obs, exp_status()); end
        do_clear();
        @(posedge Clock) #2 SDI = 1'b0;
        repeat (3) @(posedge Clock);
        #2 SDI = 1'b1;
        repeat (FB * 10 + 20) @(posedge Clock);
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL glitch got=%h exp=%h", obs, exp_status()); end
    endtask

    task automatic test_clear_midframe();
        do_clear();
        send_frame(8'h3C, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0);
            model_frame(b, 1'b1, 1'b0);
        end
        fork
            send_frame(8'h77, 1'b1, 1'b0);
            begin
                repeat (40) @(posedge Clock);
                #2 ClearData = 1'b1;
                @(posedge Clock);
                #1 checks++;
                if (obs !== 15'h0) begin failures++; $display("FAIL clear_midframe got=%h exp=%h", obs, 15'h0); end
                #1 ClearData = 1'b0;
            end
        join
        model_clear();
        model_frame(8'h77, 1'b1, 1'b0);
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL clear_then_frame got=%h exp=%h", obs, exp_status()); end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'($urandom), 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        fork
            send_frame(8'($urandom), 1'b1, 1'b0);
            begin
                repeat (45) @(posedge Clock);
                #3 Reset_n = 1'b0;
                #1 checks++;
                if (obs !== 15'h0) begin failures++; $display("FAIL reset_midframe got=%h exp=%h", obs, 15'h0); end
            end
        join
        #7 Reset_n = 1'b1;
        model_clear();
        repeat (3) @(posedge Clock);
        send_frame(8'h5A, 1'b1, 1'b0);
        model_frame(8'h5A, 1'b1, 1'b0);
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL after_reset_frame got=%h exp=%h", obs, exp_status()); end
`ifdef RXD_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b1);
        #1 checks++;
        if (obs !== exp_status()) begin failures++; $display("FAIL parity_error got=%h exp=%h", obs, exp_status()); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       sb, bp;
        int         npop;
        do_clear();
        for (int n = 0; n < 16; n++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            bp = ($urandom_range(0, 5) == 0);
`ifndef RXD_PARITY_EN
            bp = 1'b0;
`endif
            repeat ($urandom_range(0, 15)) @(posedge Clock);
            send_frame(b, sb, bp);
            model_frame(b, sb, bp);
            #1 checks++;
            if (obs !== exp_status()) begin failures++; $display("FAIL random_frame%0d got=%h exp=%h", n, obs, exp_status()); end
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                do_pop();
                #1 checks++;
                if (obs !== exp_status()) begin failures++; $display("FAIL random_pop%0d got=%h exp=%h", n, obs, exp_status()); end
            end
            if ($urandom_range(0, 9) == 0) begin
                do_clear();
                #1 checks++;
                if (obs !== exp_status()) begin failures++; $display("FAIL random_clear%0d got=%h exp=%h", n, obs, exp_status()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_clear_midframe();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
